// File: rtl/uart_ctrl_fmon_pkg.sv
// Shared types and dwell constants for the UART FIFO level monitor.
// Dwell counting is only built when UART_CTRL_FMON_DWELL_EN is defined.
package uart_ctrl_fmon_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } chan_state_e;

  typedef enum logic {
    SN_IDLE = 1'b0,
    SN_HOLD = 1'b1
  } snap_state_e;

  localparam int DWELL_W = 16;
  localparam logic [DWELL_W-1:0] DWELL_MAX = 16'hFFFF;

  // Saturating increment so a long stall never wraps back to a small count.
  function automatic logic [DWELL_W-1:0] dwell_inc(input logic [DWELL_W-1:0] d);
    if (d == DWELL_MAX) begin
      return d;
    end else begin
      return d + 16'd1;
    end
  endfunction

endpackage

// File: rtl/uart_ctrl_fmon_chan.sv
// One monitored FIFO channel: occupancy FSM, level, peak, watermark pulses, sticky errors.
// Optional full-dwell counter under UART_CTRL_FMON_DWELL_EN.
module uart_ctrl_fmon_chan
  import uart_ctrl_fmon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [LVL_W-1:0] hi_wm,
  input  logic [LVL_W-1:0] lo_wm,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] peak,
  output logic             full,
  output logic             empty,
  output logic             hi_cross,
  output logic             lo_cross,
  output logic             ovf_err,
`ifdef UART_CTRL_FMON_DWELL_EN
  output logic [DWELL_W-1:0] full_dwell,
`endif
  output logic             udf_err
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
  localparam logic [LVL_W-1:0] ZERO_L  = LVL_W'(0);

  chan_state_e      state_r, nxt_state_s;
  logic [LVL_W-1:0] level_r, nxt_level_s, peak_r;
  logic             full_r, empty_r, hi_cross_r, lo_cross_r, ovf_r, udf_r;
  logic             ovf_ev_s, udf_ev_s;

  // Next occupancy and error events; levels saturate at 0 and DEPTH.
  always_comb begin
    nxt_state_s = state_r;
    nxt_level_s = level_r;
    ovf_ev_s    = 1'b0;
    udf_ev_s    = 1'b0;
    case (state_r)
      S_EMPTY: begin
        udf_ev_s = pop;
        if (push) begin
          nxt_level_s = ONE_L;
          nxt_state_s = S_PART;
        end else begin
          nxt_level_s = ZERO_L;
          nxt_state_s = S_EMPTY;
        end
      end
      S_PART: begin
        if (push && !pop) begin
          nxt_level_s = level_r + ONE_L;
        end else if (pop && !push) begin
          nxt_level_s = level_r - ONE_L;
        end else begin
          nxt_level_s = level_r;
        end
        if (nxt_level_s == DEPTH_L) begin
          nxt_state_s = S_FULL;
        end else if (nxt_level_s == ZERO_L) begin
          nxt_state_s = S_EMPTY;
        end else begin
          nxt_state_s = S_PART;
        end
      end
      S_FULL: begin
        if (pop && !push) begin
          nxt_level_s = DEPTH_L - ONE_L;
          nxt_state_s = S_PART;
        end else begin
          ovf_ev_s    = push && !pop;
          nxt_level_s = DEPTH_L;
          nxt_state_s = S_FULL;
        end
      end
      default: begin
        nxt_level_s = ZERO_L;
        nxt_state_s = S_EMPTY;
      end
    endcase
  end

  // Channel state and all registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_EMPTY;
      level_r    <= ZERO_L;
      peak_r     <= ZERO_L;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      hi_cross_r <= 1'b0;
      lo_cross_r <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      level_r    <= nxt_level_s;
      full_r     <= (nxt_state_s == S_FULL);
      empty_r    <= (nxt_state_s == S_EMPTY);
      hi_cross_r <= (level_r < hi_wm) && (nxt_level_s >= hi_wm);
      lo_cross_r <= (level_r > lo_wm) && (nxt_level_s <= lo_wm);
      // A clear restarts peak tracking from the level that becomes visible.
      if (clr || (nxt_level_s > peak_r)) begin
        peak_r <= nxt_level_s;
      end else begin
        peak_r <= peak_r;
      end
      ovf_r <= ovf_ev_s | (ovf_r & ~clr);
      udf_r <= udf_ev_s | (udf_r & ~clr);
    end
  end

`ifdef UART_CTRL_FMON_DWELL_EN
  logic [DWELL_W-1:0] dwell_r;

  // Count cycles spent in S_FULL since reset or clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_r <= 16'd0;
    end else if (clr) begin
      dwell_r <= 16'd0;
    end else if (state_r == S_FULL) begin
      dwell_r <= dwell_inc(dwell_r);
    end else begin
      dwell_r <= dwell_r;
    end
  end

  assign full_dwell = dwell_r;
`endif

  assign level    = level_r;
  assign peak     = peak_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign hi_cross = hi_cross_r;
  assign lo_cross = lo_cross_r;
  assign ovf_err  = ovf_r;
  assign udf_err  = udf_r;

endmodule

// File: rtl/uart_ctrl_fifo_level_mon.sv
// Multi-channel FIFO occupancy monitor with a req/ack snapshot port for coverage.
// UART_CTRL_FMON_DWELL_EN adds full_dwell and snap_dwell.
module uart_ctrl_fifo_level_mon
  import uart_ctrl_fmon_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [LVL_W-1:0]        hi_wm,
  input  logic [LVL_W-1:0]        lo_wm,
  input  logic                    clr,
  output logic [NUM_CH*LVL_W-1:0] level,
  output logic [NUM_CH*LVL_W-1:0] peak,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       hi_cross,
  output logic [NUM_CH-1:0]       lo_cross,
  output logic [NUM_CH-1:0]       ovf_err,
  output logic [NUM_CH-1:0]       udf_err,
`ifdef UART_CTRL_FMON_DWELL_EN
  output logic [NUM_CH*DWELL_W-1:0] full_dwell,
  output logic [NUM_CH*DWELL_W-1:0] snap_dwell,
`endif
  input  logic                    snap_req,
  output logic                    snap_valid,
  output logic [NUM_CH*LVL_W-1:0] snap_data,
  input  logic                    snap_ack
);

  snap_state_e             snap_state_r;
  logic                    snap_valid_r;
  logic [NUM_CH*LVL_W-1:0] snap_data_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    uart_ctrl_fmon_chan #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .push       (push[i]),
      .pop        (pop[i]),
      .clr        (clr),
      .hi_wm      (hi_wm),
      .lo_wm      (lo_wm),
      .level      (level[i*LVL_W +: LVL_W]),
      .peak       (peak[i*LVL_W +: LVL_W]),
      .full       (full[i]),
      .empty      (empty[i]),
      .hi_cross   (hi_cross[i]),
      .lo_cross   (lo_cross[i]),
      .ovf_err    (ovf_err[i]),
`ifdef UART_CTRL_FMON_DWELL_EN
      .full_dwell (full_dwell[i*DWELL_W +: DWELL_W]),
`endif
      .udf_err    (udf_err[i])
    );
  end

`ifdef UART_CTRL_FMON_DWELL_EN
  logic [NUM_CH*DWELL_W-1:0] snap_dwell_r;

  // Dwell counts are captured together with the levels so the snapshot stays coherent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_dwell_r <= '0;
    end else if ((snap_state_r == SN_IDLE) && snap_req) begin
      snap_dwell_r <= full_dwell;
    end else begin
      snap_dwell_r <= snap_dwell_r;
    end
  end

  assign snap_dwell = snap_dwell_r;
`endif

  // Snapshot handshake: capture all levels in one cycle, hold until acknowledged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_state_r <= SN_IDLE;
      snap_valid_r <= 1'b0;
      snap_data_r  <= '0;
    end else begin
      case (snap_state_r)
        SN_IDLE: begin
          if (snap_req) begin
            snap_data_r  <= level;
            snap_valid_r <= 1'b1;
            snap_state_r <= SN_HOLD;
          end else begin
            snap_valid_r <= 1'b0;
          end
        end
        SN_HOLD: begin
          if (snap_ack) begin
            snap_valid_r <= 1'b0;
            snap_state_r <= SN_IDLE;
          end else begin
            snap_valid_r <= 1'b1;
          end
        end
        default: begin
          snap_valid_r <= 1'b0;
          snap_state_r <= SN_IDLE;
        end
      endcase
    end
  end

  assign snap_valid = snap_valid_r;
  assign snap_data  = snap_data_r;

endmodule

// File: tb/tb_uart_ctrl_fifo_level_mon.sv
// Self-checking bench for uart_ctrl_fifo_level_mon: directed pins plus randomized traffic
// compared every cycle against an occupancy-count reference model.
module tb_uart_ctrl_fifo_level_mon;

  localparam int NCH = 2;
  localparam int DEP = 16;
  localparam int LW  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    push, pop;
  logic [LW-1:0]     hi_wm, lo_wm;
  logic              clr;
  logic [NCH*LW-1:0] level, peak, snap_data;
  logic [NCH-1:0]    full, empty, hi_cross, lo_cross, ovf_err, udf_err;
  logic              snap_req, snap_valid, snap_ack;
`ifdef UART_CTRL_FMON_DWELL_EN
  logic [NCH*16-1:0] full_dwell, snap_dwell;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  // reference model state
  int m_lvl[NCH], m_peak[NCH];
  bit m_full[NCH], m_empty[NCH], m_hi[NCH], m_lo[NCH], m_ovf[NCH], m_udf[NCH];
  bit m_valid;
  int m_sdata;

  uart_ctrl_fifo_level_mon #(.NUM_CH(NCH), .DEPTH(DEP)) dut (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .hi_wm      (hi_wm),
    .lo_wm      (lo_wm),
    .clr        (clr),
    .level      (level),
    .peak       (peak),
    .full       (full),
    .empty      (empty),
    .hi_cross   (hi_cross),
    .lo_cross   (lo_cross),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
`ifdef UART_CTRL_FMON_DWELL_EN
    .full_dwell (full_dwell),
    .snap_dwell (snap_dwell),
`endif
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .snap_ack   (snap_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is just a count clamped to [0, DEP].
  always @(posedge clock or posedge reset) begin : model
    int nl, old;
    bit of, uf;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_lvl[i] <= 0;  m_peak[i] <= 0; m_full[i] <= 1'b0; m_empty[i] <= 1'b1;
        m_hi[i] <= 1'b0; m_lo[i] <= 1'b0; m_ovf[i] <= 1'b0; m_udf[i] <= 1'b0;
      end
      m_valid <= 1'b0;
      m_sdata <= 0;
    end else begin
      if (!m_valid && snap_req) begin
        m_valid <= 1'b1;
        m_sdata <= m_lvl[1] * 32 + m_lvl[0];
      end else if (m_valid && snap_ack) begin
        m_valid <= 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        old = m_lvl[i]; nl = old; of = 1'b0; uf = 1'b0;
        if (push[i] && pop[i]) begin
          if (old == 0) begin uf = 1'b1; nl = 1; end
        end else if (push[i]) begin
          if (old == DEP) of = 1'b1; else nl = old + 1;
        end else if (pop[i]) begin
          if (old == 0) uf = 1'b1; else nl = old - 1;
        end
        m_lvl[i]   <= nl;
        m_full[i]  <= (nl == DEP);
        m_empty[i] <= (nl == 0);
        m_hi[i]    <= (old < int'(hi_wm)) && (nl >= int'(hi_wm));
        m_lo[i]    <= (old > int'(lo_wm)) && (nl <= int'(lo_wm));
        m_peak[i]  <= clr ? nl : ((nl > m_peak[i]) ? nl : m_peak[i]);
        m_ovf[i]   <= of | (m_ovf[i] & !clr);
        m_udf[i]   <= uf | (m_udf[i] & !clr);
      end
    end
  end

  // Compare process: every output against the model once per cycle.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("level[%0d]", i), int'(level[i*LW +: LW]), m_lvl[i]);
        chk($sformatf("peak[%0d]", i), int'(peak[i*LW +: LW]), m_peak[i]);
        chk($sformatf("full[%0d]", i), int'(full[i]), int'(m_full[i]));
        chk($sformatf("empty[%0d]", i), int'(empty[i]), int'(m_empty[i]));
        chk($sformatf("hi_cross[%0d]", i), int'(hi_cross[i]), int'(m_hi[i]));
        chk($sformatf("lo_cross[%0d]", i), int'(lo_cross[i]), int'(m_lo[i]));
        chk($sformatf("ovf_err[%0d]", i), int'(ovf_err[i]), int'(m_ovf[i]));
        chk($sformatf("udf_err[%0d]", i), int'(udf_err[i]), int'(m_udf[i]));
      end
      chk("snap_valid", int'(snap_valid), int'(m_valid));
      chk("snap_data", int'(snap_data), m_sdata);
    end
  end

  task automatic cyc(input logic [1:0] p, input logic [1:0] q, input logic c);
    @(negedge clock);
    push = p; pop = q; clr = c;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_peak"}, int'(peak), 0);
    chk({tag, "_empty"}, int'(empty), 3);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_errs"}, int'({ovf_err, udf_err}), 0);
    chk({tag, "_snap_valid"}, int'(snap_valid), 0);
    chk({tag, "_snap_data"}, int'(snap_data), 0);
  endtask

  task automatic random_phase(input int n);
    int pp, qp;
    for (int k = 0; k < n; k++) begin
      if (k % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: begin pp = 80; qp = 25; end
          1: begin pp = 25; qp = 80; end
          default: begin pp = 50; qp = 50; end
        endcase
      end
      cyc({$urandom_range(0, 99) < pp, $urandom_range(0, 99) < pp},
          {$urandom_range(0, 99) < qp, $urandom_range(0, 99) < qp},
          $urandom_range(0, 63) == 0);
      snap_req = ($urandom_range(0, 2) != 0);
      snap_ack = $urandom_range(0, 1) == 1;
    end
  endtask

  initial begin : stim
    int hi_cnt, hi_lvl;
    reset = 1'b1; push = 2'b00; pop = 2'b00; clr = 1'b0;
    snap_req = 1'b0; snap_ack = 1'b0; hi_wm = 5'd12; lo_wm = 5'd4;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    chk_en = 1'b1;

    // fill ch0 to DEPTH; exactly one hi_cross pulse at level 12
    hi_cnt = 0; hi_lvl = -1;
    for (int k = 0; k <= DEP; k++) begin
      cyc((k < DEP) ? 2'b01 : 2'b00, 2'b00, 1'b0);
      if (hi_cross[0]) begin hi_cnt++; hi_lvl = int'(level[LW-1:0]); end
    end
    chk("fill_hi_pulses", hi_cnt, 1);
    chk("fill_hi_level", hi_lvl, 12);
    chk("fill_level", int'(level[LW-1:0]), 16);
    chk("fill_full", int'(full[0]), 1);
    chk("fill_peak", int'(peak[LW-1:0]), 16);

    // push&pop while full is legal; push alone overflows
    repeat (5) cyc(2'b01, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("full_pp_level", int'(level[LW-1:0]), 16);
    chk("full_pp_ovf", int'(ovf_err[0]), 0);
    cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("ovf_set", int'(ovf_err[0]), 1);
    chk("ovf_level", int'(level[LW-1:0]), 16);

    // drain, underflow, push&pop on empty, then clear
    repeat (DEP + 1) cyc(2'b00, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("udf_set", int'(udf_err[0]), 1);
    chk("udf_level", int'(level[LW-1:0]), 0);
    cyc(2'b01, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("empty_pp_level", int'(level[LW-1:0]), 1);
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 1'b0);
    chk("clr_udf", int'(udf_err[0]), 0);
    chk("clr_ovf", int'(ovf_err[0]), 0);
    chk("clr_peak", int'(peak[LW-1:0]), 1);

    // snapshot of ch0=7, ch1=3
    repeat (3) cyc(2'b11, 2'b00, 1'b0);
    repeat (3) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    snap_req = 1'b1;
    cyc(2'b00, 2'b00, 1'b0);
    chk("snap_valid_up", int'(snap_valid), 1);
    chk("snap_data_cap", int'(snap_data), 3 * 32 + 7);
    cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("snap_data_frozen", int'(snap_data), 3 * 32 + 7);
    chk("snap_live_level", int'(level[LW-1:0]), 8);
    snap_ack = 1'b1;
    cyc(2'b00, 2'b00, 1'b0);
    chk("snap_valid_down", int'(snap_valid), 0);
    snap_req = 1'b0; snap_ack = 1'b0;

    // async reset in the middle of a held snapshot
    cyc(2'b01, 2'b00, 1'b0);
    snap_req = 1'b1;
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("pre_rst_valid", int'(snap_valid), 1);
    chk("pre_rst_level", int'(level[LW-1:0]), 9);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clock);
    snap_req = 1'b0;
    reset = 1'b0;

    random_phase(3000);

    // second watermark setting, applied while in reset
    @(negedge clock);
    reset = 1'b1; push = 2'b00; pop = 2'b00; clr = 1'b0;
    snap_req = 1'b0; snap_ack = 1'b0;
    hi_wm = 5'd5; lo_wm = 5'd2;
    @(negedge clock);
    reset = 1'b0;
    random_phase(2000);

    @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
